// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving the write/read ports of an external dual-port RAM.
// Owns pointers, occupancy and flags; all RAM command outputs are registered.
module ram_fifo_ctrl #(
    parameter int ADDRESS_DEPTH = 8,
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_SIZE  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   push_data,
    input  logic                    pop,
    output logic [DATA_WIDTH-1:0]   pop_data,
    output logic                    pop_valid,
    output logic                    full,
    output logic                    empty,
    output logic [ADDRESS_SIZE:0]   count,
    output logic                    overflow,
    output logic                    underflow,
    output logic [DATA_WIDTH-1:0]   ram_wr_data,
    output logic                    ram_we,
    output logic [ADDRESS_SIZE-1:0] ram_wr_addr,
    output logic                    ram_re,
    output logic [ADDRESS_SIZE-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]   ram_rd_data
);

    localparam logic [ADDRESS_SIZE:0] DEPTH_C = (ADDRESS_SIZE+1)'(ADDRESS_DEPTH);
    localparam logic [ADDRESS_SIZE:0] PTR_ONE = {{ADDRESS_SIZE{1'b0}}, 1'b1};

    logic [ADDRESS_SIZE:0]   wptr_q, wptr_d;
    logic [ADDRESS_SIZE:0]   rptr_q, rptr_d;
    logic [ADDRESS_SIZE:0]   count_q, count_d;
    logic                    push_acc, pop_acc;
    logic                    we_q, re_q, pop_valid_q;
    logic                    overflow_q, underflow_q;
    logic [ADDRESS_SIZE-1:0] wr_addr_q, rd_addr_q;
    logic [DATA_WIDTH-1:0]   wr_data_q;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign count = count_q;

    // Acceptance uses only pre-edge flags: no fall-through when full, no bypass when empty.
    always_comb begin
        push_acc = push && !full;
        pop_acc  = pop && !empty;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        if (push_acc) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (pop_acc) begin
            rptr_d = rptr_q + PTR_ONE;
        end
        count_d = wptr_d - rptr_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            we_q        <= push_acc;
            re_q        <= pop_acc;
            pop_valid_q <= re_q;
            overflow_q  <= push && full;
            underflow_q <= pop && empty;
            if (push_acc) begin
                wr_addr_q <= wptr_q[ADDRESS_SIZE-1:0];
                wr_data_q <= push_data;
            end
            if (pop_acc) begin
                rd_addr_q <= rptr_q[ADDRESS_SIZE-1:0];
            end
        end
    end

    assign ram_we      = we_q;
    assign ram_re      = re_q;
    assign ram_wr_addr = wr_addr_q;
    assign ram_rd_addr = rd_addr_q;
    assign ram_wr_data = wr_data_q;
    assign pop_valid   = pop_valid_q;
    assign pop_data    = ram_rd_data;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: behavioural RAM plus a queue-based reference model,
// directed scenarios followed by randomized push/pop traffic.
module tb_ram_fifo_ctrl;

    localparam int DEPTH = 8;
    localparam int DW    = 16;
    localparam int AW    = 3;

    logic          clk;
    logic          rst;
    logic          push;
    logic [DW-1:0] push_data;
    logic          pop;
    logic [DW-1:0] pop_data;
    logic          pop_valid;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
    logic [DW-1:0] ram_wr_data;
    logic          ram_we;
    logic [AW-1:0] ram_wr_addr;
    logic          ram_re;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;

    ram_fifo_ctrl #(
        .ADDRESS_DEPTH(DEPTH),
        .DATA_WIDTH   (DW),
        .ADDRESS_SIZE (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .pop_data   (pop_data),
        .pop_valid  (pop_valid),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow),
        .ram_wr_data(ram_wr_data),
        .ram_we     (ram_we),
        .ram_wr_addr(ram_wr_addr),
        .ram_re     (ram_re),
        .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural dual-port RAM: registered read, contents survive reset.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_re) ram_rd_data <= mem[ram_rd_addr];
    end

    int unsigned n_chk;
    int unsigned n_pass;

    logic [DW-1:0] mq[$];
    int unsigned   pushes, pops;
    logic [AW-1:0] e_waddr, e_raddr;
    logic [DW-1:0] e_wdata, e_pd, pend_d;
    logic          e_we, e_re, e_ovf, e_unf, e_pv, pend_v;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        pushes  = 0;
        pops    = 0;
        e_waddr = '0;
        e_raddr = '0;
        e_wdata = '0;
        e_pd    = '0;
        pend_d  = '0;
        e_we    = 1'b0;
        e_re    = 1'b0;
        e_ovf   = 1'b0;
        e_unf   = 1'b0;
        e_pv    = 1'b0;
        pend_v  = 1'b0;
    endtask

    task automatic check_all();
        check_eq("ram_we",      32'(ram_we),      32'(e_we));
        check_eq("ram_re",      32'(ram_re),      32'(e_re));
        check_eq("ram_wr_addr", 32'(ram_wr_addr), 32'(e_waddr));
        check_eq("ram_wr_data", 32'(ram_wr_data), 32'(e_wdata));
        check_eq("ram_rd_addr", 32'(ram_rd_addr), 32'(e_raddr));
        check_eq("count",       32'(count),       32'(mq.size()));
        check_eq("full",        32'(full),        32'(mq.size() == DEPTH));
        check_eq("empty",       32'(empty),       32'(mq.size() == 0));
        check_eq("overflow",    32'(overflow),    32'(e_ovf));
        check_eq("underflow",   32'(underflow),   32'(e_unf));
        check_eq("pop_valid",   32'(pop_valid),   32'(e_pv));
        if (e_pv) check_eq("pop_data", 32'(pop_data), 32'(e_pd));
    endtask

    // One clock: drive at negedge, advance the model at posedge, check 1ns later.
    task automatic step(input logic p, input logic o, input logic [DW-1:0] d);
        bit was_full, was_empty;
        @(negedge clk);
        push      = p;
        pop       = o;
        push_data = d;
        @(posedge clk);
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        e_pv  = pend_v;
        e_pd  = pend_d;
        e_we  = p && !was_full;
        e_ovf = p && was_full;
        e_re  = o && !was_empty;
        e_unf = o && was_empty;
        pend_v = e_re;
        if (e_re) begin
            pend_d  = mq.pop_front();
            e_raddr = AW'(pops % DEPTH);
            pops++;
        end
        if (e_we) begin
            mq.push_back(d);
            e_waddr = AW'(pushes % DEPTH);
            e_wdata = d;
            pushes++;
        end
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, DW'($urandom));
    endtask

    // Reset asserted between edges while a read is in flight.
    task automatic mid_reset();
        if (mq.size() == 0) step(1'b1, 1'b0, 16'h5A5A);
        step(1'b0, 1'b1, 16'h0000);
        check_eq("mid_reset_re_before", 32'(ram_re), 32'd1);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b1;
        idle(3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        rst       = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = '0;
        ram_rd_data = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Single push visible on the RAM write port one cycle later.
        step(1'b1, 1'b0, 16'hF00F);
        step(1'b0, 1'b1, 16'h0000);
        idle(2);

        // Eight pushes then eight back-to-back pops; read pointer wraps.
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, DW'(i));
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h0000);
        idle(2);

        // Full: push with pop is rejected, the pop still goes through.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, DW'($urandom));
        step(1'b1, 1'b1, 16'hAAAA);
        check_eq("ovf_count7", 32'(count), 32'd7);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 16'h0000);
        idle(2);

        // Empty: pop with push is rejected, push lands; next pop returns it.
        step(1'b1, 1'b1, 16'h1234);
        step(1'b0, 1'b1, 16'h0000);
        idle(2);

        // Push 5, pop 3, push 6 across the address wrap, drain 8.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(16'h0100 + i));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h0000);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, DW'(16'h0200 + i));
        check_eq("wrap_full", 32'(full), 32'd1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h0000);
        idle(2);

        mid_reset();

        // Randomized traffic with phases biased toward full, empty and streaming.
        for (int i = 0; i < 800; i++) begin
            int unsigned pp, po;
            case ((i / 50) % 4)
                0:       begin pp = 80; po = 20; end
                1:       begin pp = 20; po = 80; end
                2:       begin pp = 50; po = 50; end
                default: begin pp = 90; po = 90; end
            endcase
            if (i == 400) mid_reset();
            step(($urandom % 100) < pp, ($urandom % 100) < po, DW'($urandom));
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
